nearest_search: RTL and testbench
=================================

NEAREST_SEARCH -- requirements
Module: nearest_search

Interface
REQ-001 Parameter N, default 16: number of memory words searched, 2..256.
REQ-002 Parameter AW, default 4: address width, ceil(log2(N)).
REQ-003 Parameter W, default 8: data and distance width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  search request; sampled in IDLE only.
REQ-007 refI  input  W  reference value; captured on accepted start.
REQ-008 mem_rd  output  1  read strobe to synchronous memory.
REQ-009 mem_addr  output  AW  read address.
REQ-010 mem_data  input  W  memory read data, valid the cycle after mem_rd.
REQ-011 busy  output  1  high from accepted start until done cycle inclusive.
REQ-012 done  output  1  one-cycle pulse, search complete.
REQ-013 best_data  output  W  value closest to captured refI.
REQ-014 best_addr  output  AW  address of best_data.
REQ-015 best_dist  output  W  |best_data - refI|.

Function
REQ-016 FSM states SHALL be IDLE, RD, CMP, DONE.
REQ-017 IDLE: start=1 -> capture refI into ref_q, addr<=0, first_q<=1, go RD; start=0 -> stay.
REQ-018 RD: mem_rd=1, mem_addr=addr; go CMP next cycle.
REQ-019 CMP: dist = |mem_data - ref_q| as unsigned W-bit magnitude, no wrap (larger minus smaller).
REQ-020 CMP: if first_q=1 or dist < best_dist (strict), load best_data<=mem_data, best_addr<=addr, best_dist<=dist; clear first_q.
REQ-021 Ties SHALL keep the existing best (lowest address wins).
REQ-022 CMP: addr==N-1 -> go DONE; else addr<=addr+1, go RD.
REQ-023 DONE: done=1 for exactly one cycle, go IDLE.
REQ-024 mem_rd SHALL be 0 in IDLE, CMP, DONE; mem_addr SHALL hold last driven value outside RD.
REQ-025 Latency: accepted start at edge k -> done high in cycle k+2N+1; busy high for 2N+1 cycles.
REQ-026 start while busy SHALL be ignored; refI changes while busy SHALL be ignored.
REQ-027 start high during DONE SHALL be ignored; start high the cycle after DONE (IDLE) SHALL begin a new search.
REQ-028 best_* SHALL update only in CMP and hold stable in IDLE and DONE until the next search's first CMP.
REQ-029 addr SHALL never exceed N-1; no wrap-around past last word.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, busy=0, done=0, mem_rd=0, mem_addr=0, best_data=0, best_addr=0, best_dist=0, ref_q=0, first_q=1.
REQ-031 rst asserted mid-search SHALL abort without a done pulse; first search after release SHALL need a new start.
REQ-032 rst released asynchronously; first state change on first rising clk edge with rst=1.

Verification
REQ-033 N=16, mem[i]=10*i, refI=47, start -> done at cycle 33 after start, best_data=50, best_addr=5, best_dist=3.
REQ-034 Tie: mem[2]=40, mem[9]=60, others 200, refI=50 -> best_addr=2, best_data=40, best_dist=10.
REQ-035 Extremes: mem[0]=255, others 0, refI=255 -> best_addr=0, best_dist=0; refI=0 with mem all 255 -> best_addr=0, best_dist=255.
REQ-036 Reset mid-search: rst=0 during RD of addr 7 -> outputs zero, no done; new start after release -> correct result for new refI.
REQ-037 Ignored start: start held high through whole search, refI changed mid-search -> single search using original refI; new search begins the cycle after done.
REQ-038 Protocol check every cycle: mem_rd only in RD, mem_addr increments 0..N-1, done one cycle wide, busy covers exactly 2N+1 cycles.

Source files
------------

// File: rtl/nearest_search.sv
// Sequential nearest-value search over an N-word synchronous memory.
// Reads each word in turn and keeps the lowest-address word closest to the captured reference.
module nearest_search #(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 4,
    parameter int unsigned W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  refI,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_data,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  best_data,
    output logic [AW-1:0] best_addr,
    output logic [W-1:0]  best_dist
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CMP,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  ref_q;
    logic [AW-1:0] addr;
    logic          first_q;
    logic [W-1:0]  dist_c;

    // Unsigned magnitude of the difference: larger minus smaller, never wraps.
    assign dist_c = (mem_data >= ref_q) ? (mem_data - ref_q) : (ref_q - mem_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ref_q     <= '0;
            addr      <= '0;
            first_q   <= 1'b1;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_data <= '0;
            best_addr <= '0;
            best_dist <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ref_q    <= refI;
                        addr     <= '0;
                        first_q  <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                        state    <= RD;
                    end
                end
                RD: begin
                    mem_rd <= 1'b0;
                    state  <= CMP;
                end
                CMP: begin
                    // Strict less-than keeps the earlier (lower-address) word on ties.
                    if (first_q || (dist_c < best_dist)) begin
                        best_data <= mem_data;
                        best_addr <= addr;
                        best_dist <= dist_c;
                    end
                    first_q <= 1'b0;
                    if (addr == LAST_ADDR) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr     <= addr + AW'(1);
                        mem_addr <= addr + AW'(1);
                        mem_rd   <= 1'b1;
                        state    <= RD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_rd <= 1'b0;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nearest_search.sv
// Directed bench for nearest_search: vector table of memory patterns and references,
// plus reset-abort and held-start sequences, with a per-cycle protocol monitor.
module tb_nearest_search;

    localparam int unsigned N  = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned LAT = 2 * N + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  refI;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_data;
    logic          busy;
    logic          done;
    logic [W-1:0]  best_data;
    logic [AW-1:0] best_addr;
    logic [W-1:0]  best_dist;

    logic [W-1:0] mem [N];

    int n_tests = 0;
    int n_fail  = 0;

    nearest_search #(.N(N), .AW(AW), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .refI     (refI),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .best_data(best_data),
        .best_addr(best_addr),
        .best_dist(best_dist)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol monitor
    logic busy_p, done_p, rd_p;
    int   exp_a, blen;
    always @(negedge clk) begin
        if (!rst) begin
            busy_p = 1'b0; done_p = 1'b0; rd_p = 1'b0; exp_a = 0; blen = 0;
        end else begin
            if (busy && !busy_p) begin
                exp_a = 0;
                blen  = 0;
            end
            if (busy) blen++;
            if (!busy && busy_p) check("busy_len", blen, LAT);
            if (mem_rd) begin
                check("rd_addr", 32'(mem_addr), exp_a);
                check("rd_busy", 32'(busy), 1);
                check("rd_gap", 32'(rd_p), 0);
                exp_a++;
            end else if (busy && exp_a > 0) begin
                check("addr_hold", 32'(mem_addr), exp_a - 1);
            end
            if (done) begin
                check("done_width", 32'(done_p), 0);
                check("done_busy", 32'(busy), 1);
                check("done_reads", exp_a, N);
            end
            busy_p = busy;
            done_p = done;
            rd_p   = mem_rd;
        end
    end

    task automatic fill(input int p);
        for (int i = 0; i < N; i++) begin
            case (p)
                0: mem[i] = W'(10 * i);
                1: mem[i] = (i == 2) ? 8'd40 : (i == 9) ? 8'd60 : 8'd200;
                2: mem[i] = (i == 0) ? 8'd255 : 8'd0;
                3: mem[i] = 8'd255;
                default: mem[i] = W'((37 * i) % 256);
            endcase
        end
    endtask

    task automatic wait_done(inout int cyc);
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_search(input logic [W-1:0] r, output int cyc);
        @(negedge clk);
        start = 1'b1;
        refI  = r;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        wait_done(cyc);
    endtask

    task automatic check_best(input string tag, input logic [W-1:0] d, input logic [AW-1:0] a,
                              input logic [W-1:0] di);
        check({tag, "_data"}, 32'(best_data), 32'(d));
        check({tag, "_addr"}, 32'(best_addr), 32'(a));
        check({tag, "_dist"}, 32'(best_dist), 32'(di));
    endtask

    typedef struct {
        int           pat;
        logic [W-1:0] refv;
        logic [W-1:0] ed;
        logic [AW-1:0] ea;
        logic [W-1:0] edist;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cyc;
        int k;

        vecs[0] = '{0, 8'd47,  8'd50,  4'd5,  8'd3};
        vecs[1] = '{0, 8'd0,   8'd0,   4'd0,  8'd0};
        vecs[2] = '{0, 8'd255, 8'd150, 4'd15, 8'd105};
        vecs[3] = '{0, 8'd45,  8'd40,  4'd4,  8'd5};
        vecs[4] = '{1, 8'd50,  8'd40,  4'd2,  8'd10};
        vecs[5] = '{2, 8'd255, 8'd255, 4'd0,  8'd0};
        vecs[6] = '{3, 8'd0,   8'd255, 4'd0,  8'd255};
        vecs[7] = '{4, 8'd100, 8'd111, 4'd3,  8'd11};

        rst   = 1'b0;
        start = 1'b0;
        refI  = '0;
        fill(0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd", 32'(mem_rd), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check_best("rst", 8'd0, 4'd0, 8'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            fill(vecs[i].pat);
            run_search(vecs[i].refv, cyc);
            check($sformatf("v%0d_latency", i), cyc, LAT);
            check_best($sformatf("v%0d", i), vecs[i].ed, vecs[i].ea, vecs[i].edist);
        end

        // Extra pattern-4 references near low and high ends.
        run_search(8'd2, cyc);
        check("p4lo_latency", cyc, LAT);
        check_best("p4lo", 8'd3, 4'd7, 8'd1);
        run_search(8'd250, cyc);
        check("p4hi_latency", cyc, LAT);
        check_best("p4hi", 8'd225, 4'd13, 8'd25);

        // Results hold in IDLE.
        repeat (4) @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check_best("hold", 8'd225, 4'd13, 8'd25);

        // Reset while reading address 7 aborts the search.
        fill(0);
        @(negedge clk);
        start = 1'b1;
        refI  = 8'd47;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(mem_rd && mem_addr == 4'd7) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_rd7", k < 100, 1);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_rd", 32'(mem_rd), 0);
        check("abort_addr", 32'(mem_addr), 0);
        check_best("abort", 8'd0, 4'd0, 8'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 0);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_stay_idle", 32'(busy), 0);
        end
        run_search(8'd100, cyc);
        check("post_abort_latency", cyc, LAT);
        check_best("post_abort", 8'd100, 4'd10, 8'd0);

        // Start held high and refI changed mid-search: one search on the original reference,
        // then a new search accepted from the IDLE cycle right after DONE.
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        refI  = 8'd47;
        @(negedge clk);
        refI = 8'd200;
        cyc  = 1;
        wait_done(cyc);
        check("held_latency", cyc, LAT);
        check_best("held", 8'd50, 4'd5, 8'd3);
        @(negedge clk);
        check("held_idle_gap", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        check("held_restart_busy", 32'(busy), 1);
        check("held_restart_rd", 32'(mem_rd), 1);
        cyc = 1;
        wait_done(cyc);
        check("restart_latency", cyc, LAT);
        check_best("restart", 8'd150, 4'd15, 8'd50);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
